// File: rtl/win_cfg_ctrl.sv
// Display-window configuration controller: key pulses edit shadow x/y/w/h
// registers with clamping, and the shadow is committed to the outputs only at frame_begin.
module win_cfg_ctrl #(
  parameter int H_ACT = 640,
  parameter int V_ACT = 480,
  parameter int STEP  = 8,
  parameter int MIN_W = 16,
  parameter int MIN_H = 16
) (
  input  logic       vga_clk,
  input  logic       sys_rst,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_mode,
  input  logic       frame_begin,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic [9:0] w,
  output logic [9:0] h,
  output logic       mode,
  output logic       key_ack,
  output logic       cfg_pending
);

  typedef enum logic [1:0] {IDLE, CALC, PEND} state_t;
  typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

  localparam logic [10:0] H_LIM  = 11'(H_ACT);
  localparam logic [10:0] V_LIM  = 11'(V_ACT);
  localparam logic [10:0] MIN_WL = 11'(MIN_W);
  localparam logic [10:0] MIN_HL = 11'(MIN_H);
  localparam logic [10:0] STEP_L = 11'(STEP);

  state_t     state, state_nxt;
  dir_t       dir, dir_nxt;
  logic       any_dir, ack_nxt, mode_tgl, calc, commit;
  logic [9:0] sx, sy, sw, sh;

  // min(v+STEP, lim), evaluated at 11 bits so the sum cannot wrap
  function automatic logic [9:0] sat_inc(input logic [9:0] v, input logic [10:0] lim);
    logic [10:0] sum;
    sum = {1'b0, v} + STEP_L;
    return (sum > lim) ? lim[9:0] : sum[9:0];
  endfunction

  // v-STEP, floored at lo
  function automatic logic [9:0] sat_dec(input logic [9:0] v, input logic [10:0] lo);
    logic [10:0] dif;
    dif = {1'b0, v} - STEP_L;
    return ({1'b0, v} < (lo + STEP_L)) ? lo[9:0] : dif[9:0];
  endfunction

  assign any_dir = key_up | key_down | key_left | key_right;

  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ack_nxt   = 1'b0;
    mode_tgl  = 1'b0;
    calc      = 1'b0;
    commit    = 1'b0;
    dir_nxt   = dir;
    case (state)
      IDLE: begin
        if (key_mode) begin
          mode_tgl = 1'b1;
          ack_nxt  = 1'b1;
        end else if (any_dir) begin
          ack_nxt   = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        calc      = 1'b1;
        state_nxt = PEND;
      end
      PEND: begin
        // frame_begin outranks every key so a commit is never delayed
        if (frame_begin) begin
          commit    = 1'b1;
          state_nxt = IDLE;
        end else if (key_mode) begin
          mode_tgl = 1'b1;
          ack_nxt  = 1'b1;
        end else if (any_dir) begin
          ack_nxt   = 1'b1;
          state_nxt = CALC;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (state_nxt == CALC) begin
      if (key_up)        dir_nxt = DIR_UP;
      else if (key_down) dir_nxt = DIR_DOWN;
      else if (key_left) dir_nxt = DIR_LEFT;
      else               dir_nxt = DIR_RIGHT;
    end
  end

  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      dir         <= DIR_UP;
      key_ack     <= 1'b0;
      mode        <= 1'b0;
      cfg_pending <= 1'b0;
    end else begin
      dir     <= dir_nxt;
      key_ack <= ack_nxt;
      if (mode_tgl) mode <= ~mode;
      if (calc)        cfg_pending <= 1'b1;
      else if (commit) cfg_pending <= 1'b0;
    end
  end

  // Shadow edit stage, then commit stage into the committed window
  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sx <= '0;
      sy <= '0;
      sw <= H_LIM[9:0];
      sh <= V_LIM[9:0];
      x  <= '0;
      y  <= '0;
      w  <= H_LIM[9:0];
      h  <= V_LIM[9:0];
    end else begin
      if (calc) begin
        if (!mode) begin
          case (dir)
            DIR_RIGHT: sx <= sat_inc(sx, H_LIM - {1'b0, sw});
            DIR_LEFT:  sx <= sat_dec(sx, 11'd0);
            DIR_DOWN:  sy <= sat_inc(sy, V_LIM - {1'b0, sh});
            default:   sy <= sat_dec(sy, 11'd0);
          endcase
        end else begin
          case (dir)
            DIR_RIGHT: sw <= sat_inc(sw, H_LIM - {1'b0, sx});
            DIR_LEFT:  sw <= sat_dec(sw, MIN_WL);
            DIR_DOWN:  sh <= sat_inc(sh, V_LIM - {1'b0, sy});
            default:   sh <= sat_dec(sh, MIN_HL);
          endcase
        end
      end
      if (commit) begin
        x <= sx;
        y <= sy;
        w <= sw;
        h <= sh;
      end
    end
  end

endmodule

// File: doc/win_cfg_ctrl.md
Name: win_cfg_ctrl

Overview:
- Display-window configuration controller that sequences the x/y/w/h window inputs of the VGA controller.
- Accepts single-cycle key pulses (key_flag style) to move or resize the window, computes clamped values into shadow registers, and commits them to the VGA controller only at frame_begin, so a frame is never drawn with a half-updated window.
- Sits between the key debouncers and vga_ctrl in the vga_clk domain.

Parameters:
H_ACT, 640, active pixels per line
V_ACT, 480, active lines per frame
STEP, 8, pixels moved/resized per key press
MIN_W, 16, minimum window width
MIN_H, 16, minimum window height

Ports:
vga_clk  input  1  pixel clock; sole clock
sys_rst  input  1  asynchronous, active-high reset
key_up  input  1  one-cycle pulse
key_down  input  1  one-cycle pulse
key_left  input  1  one-cycle pulse
key_right  input  1  one-cycle pulse
key_mode  input  1  one-cycle pulse; toggles MOVE/SIZE mode
frame_begin  input  1  one-cycle pulse from vga_ctrl at start of frame
x  output  10  committed window left edge
y  output  10  committed window top edge
w  output  10  committed window width
h  output  10  committed window height
mode  output  1  0=MOVE, 1=SIZE
key_ack  output  1  one-cycle pulse when a key is accepted
cfg_pending  output  1  shadow differs from committed, awaiting frame_begin

Behaviour:
- Reset (async, sys_rst=1):
  - x=0, y=0, w=H_ACT, h=V_ACT; shadow registers equal these values.
  - mode=0, key_ack=0, cfg_pending=0, FSM=IDLE.
  - Reset mid-operation discards pending edits.
- Key priority when several pulses coincide: mode > up > down > left > right. Only one key is accepted; the others are dropped.
- FSM states:
  - IDLE:
    - key_mode accepted: toggle mode, pulse key_ack, stay in IDLE.
    - Direction key accepted: latch key code, pulse key_ack, go to CALC.
    - frame_begin has no effect.
  - CALC (1 cycle): update shadow registers per the rules below, then go to PEND. All keys are ignored (no key_ack).
  - PEND:
    - cfg_pending=1.
    - frame_begin: copy shadow to x/y/w/h on that edge, clear cfg_pending, go to IDLE.
    - Else a direction key: accepted, key_ack, go to CALC. Edits accumulate on the shadow registers.
    - key_mode: toggles mode, stays in PEND.
    - frame_begin together with any key: frame_begin wins; the key is dropped (no key_ack).
- Latency:
  - Key sampled at edge N gives key_ack high in cycle N..N+1, shadow updated at edge N+1, cfg_pending high from edge N+1.
  - Outputs change only on an edge where frame_begin is sampled in PEND.
- Shadow arithmetic (sx, sy, sw, sh), all unsigned 10-bit, computed at 11 bits internally; no wrap-around permitted.
  - MOVE:
    - right: sx = min(sx+STEP, H_ACT-sw)
    - left: sx = (sx<STEP) ? 0 : sx-STEP
    - down: sy = min(sy+STEP, V_ACT-sh)
    - up: sy = (sy<STEP) ? 0 : sy-STEP
  - SIZE:
    - right: sw = min(sw+STEP, H_ACT-sx)
    - left: sw = (sw<MIN_W+STEP) ? MIN_W : sw-STEP
    - down: sh = min(sh+STEP, V_ACT-sy)
    - up: sh = (sh<MIN_H+STEP) ? MIN_H : sh-STEP
- Invariant at all times, shadow and committed: x+w ≤ H_ACT, y+h ≤ V_ACT, w ≥ MIN_W, h ≥ MIN_H.
- A clamped edit that changes nothing still goes through CALC/PEND and commits identical values.
- key_ack is registered, high exactly one cycle per accepted key.

Test Plan:
- Reset pulse → x=0, y=0, w=640, h=480, mode=0, cfg_pending=0, key_ack=0.
- key_mode, then 3× key_left spaced 4 cycles → key_ack ×4, mode=1, cfg_pending=1, w stays 640 until frame_begin; after frame_begin w=616, cfg_pending=0.
- Full-size window, MOVE, key_right then frame_begin → x=0 (clamped). Resize w to 100, then 70× key_right, frame_begin → x=540, x+w=640.
- SIZE, w=24, key_left → w=16 after frame_begin; key_left again → w=16.
- key_up and key_left in the same cycle in IDLE → one key_ack, only the up action applied. frame_begin coincident with key_down in PEND → commit, no key_ack, down not applied.
- sys_rst asserted while in PEND with sx=40 → outputs and shadow return to defaults, cfg_pending=0. A later frame_begin leaves x=0.
